fp_unpack: RTL and testbench
============================

# fp_unpack

Iterative operand unpacker and denormal pre-normalizer at the front of the floating-point multiplier; it is the inverse of the back-end round/pack stage. It accepts packed IEEE-754 single-precision words over a valid/ready handshake and classifies each one (zero, denormal, normal, infinity, quiet or signalling NaN). It emits sign, a signed biased exponent, and a significand with an explicit hidden bit. Denormals are left-shifted one bit per cycle until the hidden-bit position is 1, so the downstream multiplier only ever sees normalized significands.

## Interface
- WEXP, 8: exponent field width (from `fm_constants.v`).
- WSIG, 23: fraction field width (from `fm_constants.v`).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  WEXP+WSIG+1  packed operand: {sign, exp, frac}.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept; forced 0 while rst_n is low.
- out_sign  out  1  operand sign.
- out_exp  out  WEXP+2  two's-complement biased exponent; negative values are possible after denormal normalization.
- out_sig  out  WSIG+1  significand with explicit hidden bit at [WSIG].
- out_norm_shift  out  5  number of left shifts applied (0 for non-denormals).
- out_is_zero, out_is_inf, out_is_nan, out_is_snan, out_was_denorm  out  1 each  classification flags.
- out_valid  out  1  outputs are valid.
- out_ready  in  1  consumer accepts.

## Operation
- Classification is done on the accepted word, using e = exp field and f = frac field:
  - zero: e=0, f=0.
  - denormal: e=0, f≠0.
  - normal: 0<e<all-ones.
  - inf: e=all-ones, f=0.
  - NaN: e=all-ones, f≠0.
  - snan: NaN with f[WSIG-1]=0.
- Load values at accept:
  - normal: exp=e, sig={1,f}.
  - zero: exp=0, sig=0.
  - inf/NaN: exp=e, sig={0,f}.
  - denormal: exp=1, sig={0,f}, shift=0.
- States:
  - IDLE → DONE on accept of a non-denormal.
  - IDLE → NORM on accept of a denormal.
  - NORM, each cycle: sig←sig<<1, exp←exp−1, shift←shift+1. If the pre-shift sig[WSIG-1]=1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE; if a new word is accepted in the same cycle, go straight to DONE or NORM for that word.
- in_ready = rst_n & ((state==IDLE) | (state==DONE & out_ready)). Back-to-back normals therefore sustain one result per cycle.
- Outputs are registered and held stable while out_valid=1 and out_ready=0.
- NORM terminates in at most WSIG cycles, because f≠0 is guaranteed for a denormal.
- Arithmetic: exp is WEXP+2 bits signed. Minimum value is 1−WSIG = −22, so it never wraps.

## Timing
- Reset (asynchronous, any state, including mid-NORM):
  - state goes to IDLE; all outputs and flags go to 0; any in-flight operand is discarded.
  - in_ready rises combinationally once rst_n is deasserted.
- Latency, counted from the accept edge to out_valid=1:
  - non-denormal: 1 edge.
  - denormal with n leading zeros in f (n = 0 .. WSIG−1): n+2 edges, i.e. n+1 NORM shifts.
- Throughput: 1 per cycle for normals, zeros, and specials.
- in_valid may be asserted or withdrawn without restriction while in_ready=0. Transfer happens only when valid and ready are both high on the same edge.

## Structure
- Width and format constants live in the shared `fm_constants.v`, alongside existing WEXP and WSIG: all-ones exponent, quiet-NaN bit index, and shift-count width (5).
- One combinational sub-module, `fp_classify`: maps the packed word to the flags plus initial exp/sig. The top level holds the FSM, datapath registers, and handshake.

## Test plan
- 0x3FC00000 (1.5) → 1 edge later: sign=0, exp=127, sig=0xC00000, shift=0, all flags 0.
- 0x00400000 → 2 edges later: exp=0, sig=0x800000, shift=1, was_denorm=1.
- 0x80000001 → 24 edges later: sign=1, exp=−22 (0x3EA in 10 bits), sig=0x800000, shift=23, was_denorm=1.
- 0x00000000 → is_zero, exp=0, sig=0. 0x7F800000 → is_inf. 0x7FA00000 → is_nan=1, is_snan=1. 0x7FC00000 → is_snan=0.
- Four back-to-back normals with out_ready=1 → four results on four consecutive cycles. Then hold out_ready=0 for 3 cycles → outputs stable, in_ready=0.
- Assert rst_n=0 during the 10th NORM cycle of 0x00000001 → out_valid=0 and all outputs 0 immediately. After release, 0x3F800000 → exp=127, sig=0x800000.

Source files
------------

// File: rtl/fp_unpack_pkg.sv
// Shared format constants and types for the single-precision operand unpacker.
// Field widths, special exponent encoding and the classified-operand record.
package fp_unpack_pkg;

    localparam int WEXP     = 8;
    localparam int WSIG     = 23;
    localparam int WDATA    = WEXP + WSIG + 1;
    localparam int SHIFT_W  = 5;
    localparam int QNAN_BIT = WSIG - 1;

    localparam logic [WEXP-1:0] EXP_ONES = '1;

    // Two extra bits so normalized denormal exponents can go negative without wrapping.
    typedef logic signed [WEXP+1:0] exp_t;
    typedef logic [WSIG:0]          sig_t;
    typedef logic [SHIFT_W-1:0]     shift_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_DONE
    } state_t;

    typedef struct packed {
        logic sign;
        exp_t exp;
        sig_t sig;
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_snan;
        logic is_denorm;
    } cls_t;

endpackage

// File: rtl/fp_unpack_if.sv
// Operand-in / result-out channel of the unpacker, both with valid/ready handshakes.
// The slave side is the unpacker; the master side is the producer plus consumer.
interface fp_unpack_if;
    import fp_unpack_pkg::*;

    logic [WDATA-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    logic             out_sign;
    exp_t             out_exp;
    sig_t             out_sig;
    shift_t           out_norm_shift;
    logic             out_is_zero;
    logic             out_is_inf;
    logic             out_is_nan;
    logic             out_is_snan;
    logic             out_was_denorm;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_sign, out_exp, out_sig, out_norm_shift,
               out_is_zero, out_is_inf, out_is_nan, out_is_snan,
               out_was_denorm, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_sign, out_exp, out_sig, out_norm_shift,
               out_is_zero, out_is_inf, out_is_nan, out_is_snan,
               out_was_denorm, out_valid
    );

endinterface

// File: rtl/fp_classify.sv
// Combinational classifier: splits a packed single-precision word into flags
// and the initial exponent/significand the normalizer starts from.
module fp_classify
    import fp_unpack_pkg::*;
(
    input  logic [WDATA-1:0] word_i,
    output cls_t             cls_o
);

    logic [WEXP-1:0] exp_field;
    logic [WSIG-1:0] frac_field;

    assign exp_field  = word_i[WDATA-2 -: WEXP];
    assign frac_field = word_i[WSIG-1:0];

    always_comb begin
        // NOTE: default every field first so no path through the ifs can infer a latch.
        cls_o      = '0;
        cls_o.sign = word_i[WDATA-1];

        if (exp_field == '0) begin
            if (frac_field == '0) begin
                cls_o.is_zero = 1'b1;
            end else begin
                // Denormals start at the minimum normal exponent with the hidden bit clear.
                cls_o.is_denorm = 1'b1;
                cls_o.exp       = exp_t'(1);
                cls_o.sig       = {1'b0, frac_field};
            end
        end else if (exp_field == EXP_ONES) begin
            cls_o.exp = exp_t'({2'b00, exp_field});
            cls_o.sig = {1'b0, frac_field};
            if (frac_field == '0) begin
                cls_o.is_inf = 1'b1;
            end else begin
                cls_o.is_nan  = 1'b1;
                cls_o.is_snan = ~frac_field[QNAN_BIT];
            end
        end else begin
            cls_o.exp = exp_t'({2'b00, exp_field});
            cls_o.sig = {1'b1, frac_field};
        end
    end

endmodule

// File: rtl/fp_unpack.sv
// Operand unpacker: accepts packed words, classifies them and shifts denormals
// left one bit per cycle until the hidden bit is set, then presents the result.
module fp_unpack
    import fp_unpack_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    fp_unpack_if.slave     fp_if
);

    state_t state_q;
    cls_t   res_q;
    shift_t shift_q;
    cls_t   cls;
    logic   accept;

    fp_classify u_classify (
        .word_i (fp_if.in_data),
        .cls_o  (cls)
    );

    // A finished result may be replaced in the same cycle it is consumed.
    assign fp_if.in_ready = rst_n & ((state_q == S_IDLE) |
                                     ((state_q == S_DONE) & fp_if.out_ready));
    assign accept = fp_if.in_valid & fp_if.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only flops live here, so every one of them gets a reset value.
            state_q <= S_IDLE;
            res_q   <= '0;
            shift_q <= '0;
        end else if (accept) begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            res_q   <= cls;
            shift_q <= '0;
            state_q <= cls.is_denorm ? S_NORM : S_DONE;
        end else begin
            case (state_q)
                S_NORM: begin
                    res_q.sig <= res_q.sig << 1;
                    res_q.exp <= res_q.exp - exp_t'(1);
                    shift_q   <= shift_q + shift_t'(1);
                    // The bit below the hidden position becomes the hidden bit on this shift.
                    if (res_q.sig[WSIG-1]) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (fp_if.out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fp_if.out_valid      = (state_q == S_DONE);
    assign fp_if.out_sign       = res_q.sign;
    assign fp_if.out_exp        = res_q.exp;
    assign fp_if.out_sig        = res_q.sig;
    assign fp_if.out_norm_shift = shift_q;
    assign fp_if.out_is_zero    = res_q.is_zero;
    assign fp_if.out_is_inf     = res_q.is_inf;
    assign fp_if.out_is_nan     = res_q.is_nan;
    assign fp_if.out_is_snan    = res_q.is_snan;
    assign fp_if.out_was_denorm = res_q.is_denorm;

endmodule

// File: tb/tb_fp_unpack.sv
// Self-checking bench for fp_unpack: directed vectors, randomized single operands,
// streaming with random backpressure, and asynchronous reset during normalization.
module tb_fp_unpack;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] sig;
        logic [4:0]  shift;
        logic        zero;
        logic        inf;
        logic        nan;
        logic        snan;
        logic        denorm;
    } res_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    fp_unpack_if bus ();

    fp_unpack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fp_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    function automatic res_t mk(input logic s, input logic [9:0] e, input logic [23:0] g,
                                input logic [4:0] sh, input logic [4:0] fl);
        res_t r;
        r.sign   = s;
        r.exp    = e;
        r.sig    = g;
        r.shift  = sh;
        r.zero   = fl[4];
        r.inf    = fl[3];
        r.nan    = fl[2];
        r.snan   = fl[1];
        r.denorm = fl[0];
        return r;
    endfunction

    // Reference model straight from the IEEE field rules; lat = edges from accept to valid.
    function automatic res_t model(input logic [31:0] w, output int lat);
        res_t        r;
        logic [7:0]  e;
        logic [22:0] f;
        int          n;
        r   = '0;
        e   = w[30:23];
        f   = w[22:0];
        lat = 1;
        r.sign = w[31];
        if (e == 8'h00 && f == 23'h0) begin
            r.zero = 1'b1;
        end else if (e == 8'h00) begin
            n = 0;
            while (n < 22 && f[22-n] == 1'b0) n++;
            r.denorm = 1'b1;
            r.sig    = 24'({1'b0, f} << (n + 1));
            r.exp    = 10'(1 - (n + 1));
            r.shift  = 5'(n + 1);
            lat      = n + 2;
        end else if (e == 8'hFF) begin
            r.exp  = {2'b00, e};
            r.sig  = {1'b0, f};
            r.inf  = (f == 23'h0);
            r.nan  = (f != 23'h0);
            r.snan = (f != 23'h0) && !f[22];
        end else begin
            r.exp = {2'b00, e};
            r.sig = {1'b1, f};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        logic        s;
        logic [22:0] f;
        int          k;
        s = 1'($urandom);
        f = 23'($urandom);
        k = $urandom_range(0, 4);
        case (k)
            0: return {s, 8'($urandom_range(1, 254)), f};
            1: begin
                f = f >> $urandom_range(0, 22);
                if (f == 23'h0) f = 23'h1;
                return {s, 8'h00, f};
            end
            2: return {s, 31'h0};
            3: return {s, 8'hFF, ($urandom_range(0, 1) != 0) ? f : 23'h0};
            default: return $urandom;
        endcase
    endfunction

    task automatic capture(output res_t r);
        r.sign   = bus.out_sign;
        r.exp    = bus.out_exp;
        r.sig    = bus.out_sig;
        r.shift  = bus.out_norm_shift;
        r.zero   = bus.out_is_zero;
        r.inf    = bus.out_is_inf;
        r.nan    = bus.out_is_nan;
        r.snan   = bus.out_is_snan;
        r.denorm = bus.out_was_denorm;
    endtask

    // Push one word through with out_ready low until the result appears; lat=-1 on timeout.
    task automatic apply_word(input logic [31:0] w, output res_t r, output int lat);
        int n;
        @(negedge clk);
        bus.in_data   = w;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        capture(r);
        if (!bus.out_valid) lat = -1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        res_t o;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        #3;
        capture(o);
        n_vec++;
        if (o !== res_t'(0) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got out=%h valid=%b ready=%b, expected all zero",
                     o, bus.out_valid, bus.in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got ready=%b valid=%b, expected ready=1 valid=0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] words [7];
        res_t        exp_r [7];
        int          exp_l [7];
        res_t        o;
        int          lat;
        words[0] = 32'h3FC00000; exp_r[0] = mk(1'b0, 10'h07F, 24'hC00000, 5'd0,  5'b00000); exp_l[0] = 1;
        words[1] = 32'h00400000; exp_r[1] = mk(1'b0, 10'h000, 24'h800000, 5'd1,  5'b00001); exp_l[1] = 2;
        words[2] = 32'h80000001; exp_r[2] = mk(1'b1, 10'h3EA, 24'h800000, 5'd23, 5'b00001); exp_l[2] = 24;
        words[3] = 32'h00000000; exp_r[3] = mk(1'b0, 10'h000, 24'h000000, 5'd0,  5'b10000); exp_l[3] = 1;
        words[4] = 32'h7F800000; exp_r[4] = mk(1'b0, 10'h0FF, 24'h000000, 5'd0,  5'b01000); exp_l[4] = 1;
        words[5] = 32'h7FA00000; exp_r[5] = mk(1'b0, 10'h0FF, 24'h200000, 5'd0,  5'b00110); exp_l[5] = 1;
        words[6] = 32'h7FC00000; exp_r[6] = mk(1'b0, 10'h0FF, 24'h400000, 5'd0,  5'b00100); exp_l[6] = 1;
        for (int i = 0; i < 7; i++) begin
            apply_word(words[i], o, lat);
            n_vec++;
            if (o !== exp_r[i] || lat != exp_l[i]) begin
                n_err++;
                $display("FAIL directed word=%h: got out=%h lat=%0d, expected out=%h lat=%0d",
                         words[i], o, lat, exp_r[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_random_single();
        logic [31:0] w;
        res_t        o;
        res_t        e;
        int          lat;
        int          elat;
        for (int i = 0; i < 40; i++) begin
            w = rand_word();
            e = model(w, elat);
            apply_word(w, o, lat);
            n_vec++;
            if (o !== e || lat != elat) begin
                n_err++;
                $display("FAIL random_single word=%h: got out=%h lat=%0d, expected out=%h lat=%0d",
                         w, o, lat, e, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [5];
        res_t        o;
        res_t        e;
        int          dummy;
        for (int i = 0; i < 5; i++)
            w[i] = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = w[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            capture(o);
            e = model(w[i], dummy);
            n_vec++;
            if (o !== e || bus.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got out=%h valid=%b, expected out=%h valid=1",
                         i, o, bus.out_valid, e);
            end
            bus.in_data = w[i + 1];
        end
        bus.out_ready = 1'b0;
        e = model(w[3], dummy);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            capture(o);
            n_vec++;
            if (o !== e || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold[%0d]: got out=%h valid=%b ready=%b, expected out=%h valid=1 ready=0",
                         i, o, bus.out_valid, bus.in_ready, e);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        capture(o);
        e = model(w[4], dummy);
        n_vec++;
        if (o !== e || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL after_hold: got out=%h valid=%b, expected out=%h valid=1",
                     o, bus.out_valid, e);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_idle: got valid=%b, expected 0", bus.out_valid);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stream();
        res_t q [$];
        res_t o;
        res_t e;
        int   dummy;
        int   budget;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_data   = rand_word();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                capture(o);
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream: unexpected result out=%h, expected none", o);
                end else begin
                    e = q.pop_front();
                    if (o !== e) begin
                        n_err++;
                        $display("FAIL stream cyc=%0d: got out=%h, expected out=%h", cyc, o, e);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_data, dummy));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        budget = 0;
        while (q.size() > 0 && budget < 200) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) begin
                capture(o);
                e = q.pop_front();
                n_vec++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL stream_drain: got out=%h, expected out=%h", o, e);
                end
            end
            budget++;
        end
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL stream_timeout: got %0d results outstanding, expected 0", q.size());
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_norm();
        res_t o;
        int   lat;
        @(negedge clk);
        bus.in_data   = 32'h00000001;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        capture(o);
        n_vec++;
        if (o !== res_t'(0) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_norm: got out=%h valid=%b ready=%b, expected all zero",
                     o, bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got %b, expected 1", bus.in_ready);
        end
        apply_word(32'h3F800000, o, lat);
        n_vec++;
        if (o !== mk(1'b0, 10'h07F, 24'h800000, 5'd0, 5'b00000) || lat != 1) begin
            n_err++;
            $display("FAIL post_reset_one: got out=%h lat=%0d, expected exp=07f sig=800000 lat=1",
                     o, lat);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_random_single();
        test_back_to_back();
        test_stream();
        test_reset_mid_norm();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
